// File: rtl/lshift_8_pipe.sv
// Three-stage pipelined 8-bit left shifter/rotator (stages shift by 1, 2, 4).
// Valid/ready on both sides; a full pipe sustains one word per cycle under continuous drain.
module lshift_8_pipe #(
    parameter logic FILL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data,
    input  logic [2:0] sel,
    input  logic       rotate,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out,
    output logic [7:0] xfer_count
);

    // The low byte supplies the bits that fill vacated LSBs: the operand itself when rotating.
    function automatic logic [7:0] shl(input logic [7:0] src, input logic [2:0] k,
                                       input logic rot);
        logic [15:0] wide;
        wide = {src, (rot ? src : {8{FILL}})} << k;
        return wide[15:8];
    endfunction

    logic       v1, v2, v3;
    logic [7:0] d1, d2, d3;
    logic [1:0] s1;
    logic       s2;
    logic       r1, r2;
    logic       advance1, advance2, advance3;

    assign advance3  = !v3 || out_ready;
    assign advance2  = !v2 || advance3;
    assign advance1  = !v1 || advance2;
    assign in_ready  = advance1 && !rst;
    assign out_valid = v3;
    assign out       = d3;

    // S1: capture operand and apply the 1-bit shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= 8'h00;
            s1 <= 2'b00;
            r1 <= 1'b0;
        end else if (advance1) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= shl(data, {2'b00, sel[0]}, rotate);
                s1 <= sel[2:1];
                r1 <= rotate;
            end
        end
    end

    // S2: 2-bit shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            d2 <= 8'h00;
            s2 <= 1'b0;
            r2 <= 1'b0;
        end else if (advance2) begin
            v2 <= v1;
            if (v1) begin
                d2 <= shl(d1, {1'b0, s1[0], 1'b0}, r1);
                s2 <= s1[1];
                r2 <= r1;
            end
        end
    end

    // S3: 4-bit shift; these registers drive the output port.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3 <= 1'b0;
            d3 <= 8'h00;
        end else if (advance3) begin
            v3 <= v2;
            if (v2) begin
                d3 <= shl(d2, {s2, 2'b00}, r2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= 8'h00;
        end else if (v3 && out_ready) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end

endmodule
